// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types, tick constants and helpers for the 16x oversampled UART receiver
// Contents: receiver FSM state encoding, tick positions within a 16-tick bit cell, maj3 voter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_t;

  // Tick positions inside one 16-tick bit cell.
  localparam logic [3:0] START_SAMPLE   = 4'd7;
  localparam logic [3:0] DATA_SAMPLE_LO = 4'd7;
  localparam logic [3:0] DATA_SAMPLE_HI = DATA_SAMPLE_LO + 4'd2;
  localparam logic [3:0] BIT_END        = 4'd15;
  localparam logic [3:0] STOP_SAMPLE    = 4'd8;

  // The start vote needs the sample one tick past the centre to complete its window.
  localparam logic [3:0] START_DECIDE   = START_SAMPLE + 4'd1;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - synchronous receive FIFO holding {err, data} entries
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   push, push_data    write request and entry; ignored when full unless popping in the same clk
//   pop                read request; ignored when empty
//   pop_data           current head entry
//   full, empty        occupancy flags
module uart_rx_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_data;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/uart_rx_os16.sv
// rtl/uart_rx_os16.sv - 16x oversampled UART receiver with rx_rdy/rx_read handshake
// Optional build macro: UART_RX_FIFO_EN (FIFO_DEPTH-entry receive FIFO instead of a holding register).
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   mclkx16     one-clk enable at 16x baud; the receiver FSM only advances on it
//   rx          asynchronous serial line, idle high
//   rx_read     one-clk pulse: consumer has taken rx_data
//   rx_rdy      character available
//   rx_data     received character (unused upper bits 0)
//   rx_err      framing error on the character in rx_data
//   rx_ovr      sticky overrun since the last rx_read
module uart_rx_os16
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mclkx16,
  input  logic       rx,
  input  logic       rx_read,
  output logic       rx_rdy,
  output logic [7:0] rx_data,
  output logic       rx_err,
  output logic       rx_ovr
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);
  localparam int         SHIFT    = 8 - DATA_BITS;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   rx_s;

  rx_state_t  state_q, state_d;
  logic [3:0] tick_q, tick_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic [7:0] shreg_q, shreg_d;
  logic [1:0] samp_q, samp_d;
  logic       bit_q, bit_d;
  logic       deliver_q, deliver_d;
  logic [7:0] dlv_data_q, dlv_data_d;
  logic       dlv_err_q, dlv_err_d;
  logic       vote;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], rx};
  assign rx_s   = sync_q[SYNC_STAGES-1];

  // Three-sample window ending at the current tick: two previous ticks plus now.
  assign vote = maj3(samp_q[1], samp_q[0], rx_s);

  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    bitcnt_d   = bitcnt_q;
    shreg_d    = shreg_q;
    samp_d     = samp_q;
    bit_d      = bit_q;
    deliver_d  = 1'b0;
    dlv_data_d = dlv_data_q;
    dlv_err_d  = dlv_err_q;
    if (mclkx16) begin
      samp_d = {samp_q[0], rx_s};
      tick_d = tick_q + 4'd1;
      case (state_q)
        IDLE: begin
          tick_d = 4'd0;
          if (!rx_s) state_d = START;
        end
        START: begin
          // After a valid vote, stay in START to the end of the start cell so
          // DATA tick 0 lines up with the first data cell boundary.
          if (tick_q == START_DECIDE && vote) begin
            state_d = IDLE;
            tick_d  = 4'd0;
          end else if (tick_q == BIT_END) begin
            state_d  = DATA;
            bitcnt_d = 3'd0;
          end
        end
        DATA: begin
          if (tick_q == DATA_SAMPLE_HI) bit_d = vote;
          if (tick_q == BIT_END) begin
            shreg_d = {bit_q, shreg_q[7:1]};
            if (bitcnt_q == LAST_BIT) state_d = STOP;
            else bitcnt_d = bitcnt_q + 3'd1;
          end
        end
        STOP: begin
          if (tick_q == STOP_SAMPLE) begin
            deliver_d  = 1'b1;
            dlv_data_d = shreg_q >> SHIFT;
            dlv_err_d  = ~vote;
            state_d    = vote ? IDLE : BREAK;
            tick_d     = 4'd0;
          end
        end
        BREAK: begin
          tick_d = 4'd0;
          if (rx_s) state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          tick_d  = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q     <= '1;
      state_q    <= IDLE;
      tick_q     <= 4'd0;
      bitcnt_q   <= 3'd0;
      shreg_q    <= 8'h00;
      samp_q     <= 2'b11;
      bit_q      <= 1'b1;
      deliver_q  <= 1'b0;
      dlv_data_q <= 8'h00;
      dlv_err_q  <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      state_q    <= state_d;
      tick_q     <= tick_d;
      bitcnt_q   <= bitcnt_d;
      shreg_q    <= shreg_d;
      samp_q     <= samp_d;
      bit_q      <= bit_d;
      deliver_q  <= deliver_d;
      dlv_data_q <= dlv_data_d;
      dlv_err_q  <= dlv_err_d;
    end
  end

`ifdef UART_RX_FIFO_EN

  logic       pop, fifo_full, fifo_empty;
  logic [8:0] fifo_head;
  logic       pop_q, pop_d;
  logic       rx_ovr_q, rx_ovr_d;

  // rx_rdy is forced low one clk after each pop so every queued character
  // presents a fresh rising edge to the edge-detecting consumer.
  assign rx_rdy  = ~fifo_empty & ~pop_q;
  assign pop     = rx_read & rx_rdy;
  assign rx_data = fifo_head[7:0];
  assign rx_err  = fifo_head[8];
  assign rx_ovr  = rx_ovr_q;

  uart_rx_fifo #(
    .WIDTH (9),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (deliver_q),
    .push_data ({dlv_err_q, dlv_data_q}),
    .pop       (pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    pop_d    = pop;
    rx_ovr_d = rx_ovr_q;
    if (deliver_q && fifo_full && !pop) rx_ovr_d = 1'b1;
    else if (pop)                       rx_ovr_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pop_q    <= 1'b0;
      rx_ovr_q <= 1'b0;
    end else begin
      pop_q    <= pop_d;
      rx_ovr_q <= rx_ovr_d;
    end
  end

`else

  logic       rx_rdy_q, rx_rdy_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_err_q, rx_err_d;
  logic       rx_ovr_q, rx_ovr_d;
  logic       read_eff;

  assign read_eff = rx_read & rx_rdy_q;
  assign rx_rdy   = rx_rdy_q;
  assign rx_data  = rx_data_q;
  assign rx_err   = rx_err_q;
  assign rx_ovr   = rx_ovr_q;

  always_comb begin
    rx_rdy_d  = rx_rdy_q;
    rx_data_d = rx_data_q;
    rx_err_d  = rx_err_q;
    rx_ovr_d  = rx_ovr_q;
    if (deliver_q) begin
      // A delivery always wins over a read: new data loads and rx_rdy holds.
      rx_data_d = dlv_data_q;
      rx_err_d  = dlv_err_q;
      rx_rdy_d  = 1'b1;
      if (rx_rdy_q && !rx_read) rx_ovr_d = 1'b1;
      else if (read_eff)        rx_ovr_d = 1'b0;
    end else if (read_eff) begin
      rx_rdy_d = 1'b0;
      rx_ovr_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_rdy_q  <= 1'b0;
      rx_data_q <= 8'h00;
      rx_err_q  <= 1'b0;
      rx_ovr_q  <= 1'b0;
    end else begin
      rx_rdy_q  <= rx_rdy_d;
      rx_data_q <= rx_data_d;
      rx_err_q  <= rx_err_d;
      rx_ovr_q  <= rx_ovr_d;
    end
  end

`endif

endmodule

// File: doc/uart_rx_os16.md
Name: uart_rx_os16

Overview:
- 16x-oversampled asynchronous serial receiver. Sits directly upstream of the teletype/keyboard device.
- Turns the serial `tty_rx` line into bytes and presents them on the `rx_rdy` / `rx_data` / `rx_read` handshake that the keyboard flag logic consumes.
- Sample timing comes from the shared one-cycle `mclkx16` enable produced by the baud generator.

Parameters:
- DATA_BITS, 8, data bits per frame (7 or 8); LSB first; unused upper `rx_data` bits read 0.
- SYNC_STAGES, 2, flops in the rx input synchronizer (minimum 2).
- FIFO_DEPTH, 4, receive FIFO entries (power of 2); only used when UART_RX_FIFO_EN is defined.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- mclkx16  in  1  one-clk enable pulse at 16x baud rate.
- rx  in  1  serial line; idle high; asynchronous to clk.
- rx_read  in  1  one-clk pulse: consumer has taken `rx_data`.
- rx_rdy  out  1  character available.
- rx_data  out  8  received character.
- rx_err  out  1  framing error on the character in `rx_data` (stop bit sampled low).
- rx_ovr  out  1  sticky overrun: a character was lost since the last `rx_read`.

Behaviour:
- Reset (async, active-high): `rx_rdy`=0, `rx_data`=8'h00, `rx_err`=0, `rx_ovr`=0, FSM=IDLE, synchronizer flops=1, tick counter=0, bit counter=0.
- All FSM activity advances only on clk edges where `mclkx16`=1. The handshake logic (`rx_read`, flag updates) runs every clk.
- FSM states and transitions:
  - IDLE: synced rx=0 -> START, tick counter=0.
  - START: at tick 7 (mid start bit), take the majority of ticks 6,7,8. If 1 -> false start, back to IDLE with no output change. If 0 -> DATA, bit counter=0, tick counter=0.
  - DATA: each bit spans 16 ticks. The bit value is the majority of samples at ticks 7,8,9. The bit is shifted in LSB-first on tick 15. After DATA_BITS bits -> STOP.
  - STOP: at tick 8, sample the majority. 1 -> deliver the character with err=0, go to IDLE. 0 -> deliver the character with err=1, go to BREAK.
  - BREAK: wait for synced rx=1, then IDLE. A held-low line produces only one character.
- Delivery (non-FIFO build):
  - `rx_data` and `rx_err` load on the same clk that `rx_rdy` is set.
  - `rx_rdy` stays high until `rx_read`; it clears on the clk after the `rx_read` pulse.
- Overrun: a character is delivered while `rx_rdy`=1 and `rx_read`=0.
  - New data overwrites `rx_data`.
  - `rx_ovr` sets.
  - `rx_rdy` stays 1, so there is no new rising edge.
- Simultaneous `rx_read` and delivery: new data loads, `rx_rdy` stays 1, no overrun.
- `rx_ovr` clears on `rx_read`, unless an overrun occurs in the same clk; set wins.
- `rx_read` while `rx_rdy`=0 is ignored.
- Latency: `rx_rdy` rises 1 clk after the `mclkx16` tick 8 of the stop bit. This is roughly 9.5 bit times after the start edge, plus SYNC_STAGES clks.
- `mclkx16` stuck low: FSM frozen, handshake still functional.

Optional Feature:
- Macro: UART_RX_FIFO_EN.
- Defined:
  - Delivered characters (with their err bit) push into a FIFO_DEPTH entry FIFO.
  - `rx_data` and `rx_err` show the FIFO head. `rx_read` pops.
  - Push on full: drop the new character and set `rx_ovr`.
  - Push and pop in the same clk on a full FIFO: both happen, no overrun.
  - `rx_rdy` = not-empty, except that it is forced low for exactly one clk after every pop. The keyboard flag logic, which is rising-edge detected, therefore sees a fresh edge for each queued character.
- Not defined: single holding register as described above. No FIFO storage is synthesized.

Decomposition:
- Shared package `uart_pkg`:
  - FSM state encoding (IDLE, START, DATA, STOP, BREAK).
  - Tick constants: START_SAMPLE=7, DATA_SAMPLE_LO=7, DATA_SAMPLE_HI=9, BIT_END=15, STOP_SAMPLE=8.
  - `maj3` function.
- Sub-module `uart_rx_fifo` (sync FIFO with push/pop/full/empty, width 9 = data+err). Instantiated only under UART_RX_FIFO_EN.

Test Plan:
- Bench drives `mclkx16` every 4 clks. Send 8N1 byte 8'hA5, then assert `rx_read` 3 clks after `rx_rdy` rises:
  - required: `rx_rdy` rises once, `rx_data`=8'hA5, `rx_err`=0;
  - `rx_rdy` low the clk after `rx_read`.
- 3-tick low glitch on idle rx -> no `rx_rdy`, FSM back in IDLE, a following 8'h3C frame received correctly.
- Frame 8'h55 with stop bit held low for 2 bit times, then high:
  - required: exactly one `rx_rdy`, `rx_data`=8'h55, `rx_err`=1;
  - next frame 8'h0F has `rx_err`=0.
- Bytes 8'h11 and 8'h22 back-to-back with no `rx_read`:
  - non-FIFO build: `rx_data`=8'h22, `rx_ovr`=1, `rx_rdy` stays 1;
  - `rx_read` clears `rx_rdy` and `rx_ovr`.
- Assert `rst` mid-DATA of a frame:
  - all outputs return to reset values immediately (async);
  - after release, the next full frame 8'h7E is received correctly.
- UART_RX_FIFO_EN, send 8'h01..8'h05 with no reads:
  - reads return 8'h01..8'h04 in order;
  - `rx_ovr`=1;
  - `rx_rdy` low for one clk after each pop, then high while the FIFO is non-empty.
